// File: rtl/fir_channel_arbiter.sv
// Per-channel input FIFOs merged round-robin onto one AXI-Stream tagged with the channel on tuser.
// Optional per-channel input stall counters are enabled by defining FIR_ARB_STALL_CNT_EN.
module fir_channel_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arstn,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [1:0]               m_axis_tuser,
  output logic [NUM_CH*4-1:0]      fifo_level
`ifdef FIR_ARB_STALL_CNT_EN
  ,
  output logic [NUM_CH*16-1:0]     stall_cnt
`endif
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [CW-1:0]     count  [NUM_CH];
  logic [NUM_CH-1:0] full, empty, push, pop, elig;
  logic [1:0]        last_grant, winner;
  logic [DATA_W-1:0] head;
  logic              any_elig, load;

  always_comb begin
    full          = '0;
    empty         = '0;
    s_axis_tready = '0;
    push          = '0;
    elig          = '0;
    fifo_level    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      full[i]                = (count[i] == CW'(FIFO_DEPTH));
      empty[i]               = (count[i] == '0);
      s_axis_tready[i]       = s_axis_arstn & (ch_en[i] ? !full[i] : 1'b1);
      push[i]                = s_axis_tvalid[i] & s_axis_tready[i] & ch_en[i];
      elig[i]                = ch_en[i] & !empty[i];
      fifo_level[i*4 +: 4]   = (count[i] > 15) ? 4'hF : 4'(count[i]);
    end
  end

  // Search last_grant+1, last_grant+2, ... modulo NUM_CH; first eligible wins.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    winner   = last_grant;
    any_elig = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last_grant) + k) % NUM_CH;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!any_elig && (i == idx) && elig[i]) begin
          any_elig = 1'b1;
          winner   = 2'(i);
        end
      end
    end
    load = (!m_axis_tvalid | m_axis_tready) & any_elig;
    pop  = '0;
    head = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pop[i] = load && (winner == 2'(i));
      if (pop[i]) head = mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= s_axis_tdata[i*DATA_W +: DATA_W];
    end
  end

  // Holding a disabled channel's FIFO cleared flushes it on the edge after ch_en falls;
  // writes are already dropped while disabled, so nothing else is lost.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!ch_en[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
          else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      last_grant    <= 2'(NUM_CH - 1);
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= head;
      m_axis_tuser  <= winner;
      last_grant    <= winner;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef FIR_ARB_STALL_CNT_EN
  logic [NUM_CH-1:0] en_q;
  logic [15:0]       stall [NUM_CH];

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      en_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) stall[i] <= '0;
    end else begin
      en_q <= ch_en;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_en[i] && !en_q[i])
          stall[i] <= '0;
        else if (s_axis_tvalid[i] && !s_axis_tready[i] && ch_en[i] && (stall[i] != '1))
          stall[i] <= stall[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) stall_cnt[i*16 +: 16] = stall[i];
  end
`endif

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed bench for fir_channel_arbiter: reset, latency, round-robin order, backpressure,
// disable flush, async reset, and (with FIR_ARB_STALL_CNT_EN) the stall counters.
module tb_fir_channel_arbiter;
  logic         clk = 1'b0;
  logic         arstn;
  logic [3:0]   ch_en;
  logic [127:0] s_tdata;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic [1:0]   m_tuser;
  logic [15:0]  fifo_level;
`ifdef FIR_ARB_STALL_CNT_EN
  logic [63:0]  stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_channel_arbiter #(.NUM_CH(4), .FIFO_DEPTH(4), .DATA_W(32)) dut (
    .s_axis_aclk   (clk),
    .s_axis_arstn  (arstn),
    .ch_en         (ch_en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .fifo_level    (fifo_level)
`ifdef FIR_ARB_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [31:0] val);
    s_tdata[ch*32 +: 32] = val;
  endtask

  task automatic pulse_reset();
    @(negedge clk) arstn = 1'b0;
    @(negedge clk) arstn = 1'b1;
  endtask

  initial begin
    arstn    = 1'b0;
    ch_en    = '0;
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    #12;
    chk("rst_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_tdata",  m_tdata, 32'h0);
    chk("rst_tuser",  32'(m_tuser), 32'h0);
    chk("rst_level",  32'(fifo_level), 32'h0);
    chk("rst_tready", 32'(s_tready), 32'h0);

    // Single beat on ch2: visible one edge after acceptance
    ch_en    = 4'hF;
    m_tready = 1'b1;
    @(negedge clk) arstn = 1'b1;
    #1;
    chk("idle_tready", 32'(s_tready), 32'hF);
    s_tvalid = 4'b0100;
    set_data(2, 32'h11);
    step();
    s_tvalid = '0;
    chk("lat_level_k",  32'(fifo_level), 32'h0100);
    chk("lat_tvalid_k", 32'(m_tvalid), 32'h0);
    step();
    chk("lat_tvalid_k1", 32'(m_tvalid), 32'h1);
    chk("lat_tdata",     m_tdata, 32'h11);
    chk("lat_tuser",     32'(m_tuser), 32'h2);
    chk("lat_level_k1",  32'(fifo_level), 32'h0);
    step();
    chk("lat_drain", 32'(m_tvalid), 32'h0);

    // Round-robin over all four channels, three beats each
    pulse_reset();
    s_tvalid = 4'hF;
    for (int c = 0; c < 4; c++) set_data(c, 32'(c*16));
    step();
    for (int c = 0; c < 4; c++) set_data(c, 32'(c*16 + 1));
    step();
    chk("rr_data_0", m_tdata, 32'h00);
    chk("rr_user_0", 32'(m_tuser), 32'h0);
    for (int c = 0; c < 4; c++) set_data(c, 32'(c*16 + 2));
    step();
    s_tvalid = '0;
    chk("rr_data_1", m_tdata, 32'h10);
    chk("rr_user_1", 32'(m_tuser), 32'h1);
    for (int n = 2; n < 12; n++) begin
      step();
      chk($sformatf("rr_valid_%0d", n), 32'(m_tvalid), 32'h1);
      chk($sformatf("rr_data_%0d", n),  m_tdata, 32'((n % 4) * 16 + n / 4));
      chk($sformatf("rr_user_%0d", n),  32'(m_tuser), 32'(n % 4));
    end
    step();
    chk("rr_end", 32'(m_tvalid), 32'h0);

    // Backpressure: ch1 takes 1 + FIFO_DEPTH beats then stalls
    m_tready = 1'b0;
    s_tvalid = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      set_data(1, 32'hA0 + 32'(n));
      step();
    end
    set_data(1, 32'hA5);
    chk("bp_tready", 32'(s_tready), 32'hD);
    chk("bp_level",  32'(fifo_level), 32'h0040);
    chk("bp_tdata",  m_tdata, 32'hA0);
    step(2);
    chk("bp_level_hold", 32'(fifo_level), 32'h0040);
    chk("bp_tdata_hold", m_tdata, 32'hA0);
    chk("bp_tvalid_hold", 32'(m_tvalid), 32'h1);
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int n = 1; n < 5; n++) begin
      step();
      chk($sformatf("bp_drain_%0d", n), m_tdata, 32'hA0 + 32'(n));
    end
    step();
    chk("bp_end_valid", 32'(m_tvalid), 32'h0);
    chk("bp_end_level", 32'(fifo_level), 32'h0);

    // Disable ch3 while its first beat sits in the output register
    m_tready = 1'b0;
    s_tvalid = 4'b1000;
    set_data(3, 32'hB0);
    step();
    set_data(3, 32'hB1);
    step();
    s_tvalid = '0;
    chk("dis_level_pre", 32'(fifo_level), 32'h1000);
    ch_en = 4'h7;
    step();
    chk("dis_level",  32'(fifo_level), 32'h0);
    chk("dis_tready", 32'(s_tready), 32'hF);
    chk("dis_tvalid", 32'(m_tvalid), 32'h1);
    chk("dis_tdata",  m_tdata, 32'hB0);
    chk("dis_tuser",  32'(m_tuser), 32'h3);
    s_tvalid = 4'b1000;
    set_data(3, 32'hC0);
    step();
    s_tvalid = '0;
    chk("dis_drop_level", 32'(fifo_level), 32'h0);
    m_tready = 1'b1;
    step();
    chk("dis_no_b1", 32'(m_tvalid), 32'h0);
    ch_en = 4'hF;
    step();

    // Asynchronous reset mid-burst
    m_tready = 1'b0;
    s_tvalid = 4'b0110;
    set_data(1, 32'hD1);
    set_data(2, 32'hD2);
    step();
    s_tvalid = '0;
    step();
    chk("ar_pre_tdata", m_tdata, 32'hD1);
    chk("ar_pre_tuser", 32'(m_tuser), 32'h1);
    #2 arstn = 1'b0;
    #1;
    chk("ar_tvalid", 32'(m_tvalid), 32'h0);
    chk("ar_tdata",  m_tdata, 32'h0);
    chk("ar_level",  32'(fifo_level), 32'h0);
    chk("ar_tready", 32'(s_tready), 32'h0);
    @(negedge clk) arstn = 1'b1;
    s_tvalid = 4'hF;
    for (int c = 0; c < 4; c++) set_data(c, 32'hE0 + 32'(c));
    m_tready = 1'b1;
    step();
    s_tvalid = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("ar_grant_user_%0d", c), 32'(m_tuser), 32'(c));
      chk($sformatf("ar_grant_data_%0d", c), m_tdata, 32'hE0 + 32'(c));
    end
    step();

`ifdef FIR_ARB_STALL_CNT_EN
    // Stall counter on ch0 with the downstream blocked
    pulse_reset();
    m_tready = 1'b0;
    s_tvalid = 4'b0001;
    set_data(0, 32'h55);
    step(5);
    chk("st_tready", 32'(s_tready[0]), 32'h0);
    chk("st_zero",   32'(stall_cnt[15:0]), 32'h0);
    step(100);
    chk("st_100",    32'(stall_cnt[15:0]), 32'd100);
    chk("st_ch1",    32'(stall_cnt[31:16]), 32'h0);
    step(70000);
    chk("st_sat",    32'(stall_cnt[15:0]), 32'hFFFF);
    s_tvalid = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
